alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the shared 16-bit ALU (A, B, Cin, 4-bit OP → C, Cout). Each requester submits an operation over a valid/ready handshake. The block time-multiplexes the single ALU instance and returns the result over a per-port valid/ready response channel. A wide mode runs a 32-bit add as two chained ALU passes, carrying the low-half Cout into the high-half Cin.

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end that time-multiplexes one W-bit ALU.
// A wide add (op 0) runs as two chained passes, low half first.
module alu_arbiter #(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [3:0]     req0_op,
   input  logic           req0_wide,
   input  logic           req0_cin,
   input  logic [2*W-1:0] req0_a,
   input  logic [2*W-1:0] req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [3:0]     req1_op,
   input  logic           req1_wide,
   input  logic           req1_cin,
   input  logic [2*W-1:0] req1_a,
   input  logic [2*W-1:0] req1_b,
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic [2*W-1:0] rsp0_data,
   output logic           rsp0_cout,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [2*W-1:0] rsp1_data,
   output logic           rsp1_cout,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [3:0]     alu_op,
   output logic           alu_cin,
   input  logic [W-1:0]   alu_c,
   input  logic           alu_cout
);

   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   state_t         state, next_state;
   logic           last_grant;
   logic           elig0, elig1, accept, sel, done;
   logic [3:0]     op_r;
   logic           wide_r, cin_r, port_r, carry_r;
   logic [2*W-1:0] a_r, b_r;
   logic [W-1:0]   res_lo;
   logic [3:0]     acc_op;
   logic           acc_wide, acc_cin;
   logic [2*W-1:0] acc_a, acc_b, fin_data;

   // A port holding an undrained response is not eligible for a new grant.
   assign elig0    = req0_valid & ~rsp0_valid;
   assign elig1    = req1_valid & ~rsp1_valid;
   assign accept   = req0_ready | req1_ready;
   assign sel      = req1_ready;
   assign acc_op   = sel ? req1_op  : req0_op;
   assign acc_cin  = sel ? req1_cin : req0_cin;
   assign acc_a    = sel ? req1_a   : req0_a;
   assign acc_b    = sel ? req1_b   : req0_b;
   assign acc_wide = (sel ? req1_wide : req0_wide) & (acc_op == 4'd0);
   assign fin_data = (state == HI) ? {alu_c, res_lo} : {{W{1'b0}}, alu_c};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_op     = '0;
      alu_cin    = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            // On a tie the port that did not win last time goes first.
            req0_ready = ~rst & elig0 & (~elig1 | last_grant);
            req1_ready = ~rst & elig1 & (~elig0 | ~last_grant);
            if (req0_ready | req1_ready) next_state = LO;
         end
         LO: begin
            alu_a   = a_r[W-1:0];
            alu_b   = b_r[W-1:0];
            alu_op  = op_r;
            alu_cin = cin_r;
            if (wide_r) begin
               next_state = HI;
            end else begin
               next_state = IDLE;
               done       = 1'b1;
            end
         end
         HI: begin
            alu_a      = a_r[2*W-1:W];
            alu_b      = b_r[2*W-1:W];
            alu_cin    = carry_r;
            next_state = IDLE;
            done       = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
         op_r       <= '0;
         wide_r     <= 1'b0;
         cin_r      <= 1'b0;
         port_r     <= 1'b0;
         a_r        <= '0;
         b_r        <= '0;
         res_lo     <= '0;
         carry_r    <= 1'b0;
      end else begin
         if (accept) begin
            op_r       <= acc_op;
            wide_r     <= acc_wide;
            cin_r      <= acc_cin;
            a_r        <= acc_a;
            b_r        <= acc_b;
            port_r     <= sel;
            last_grant <= sel;
         end
         if (state == LO) begin
            res_lo  <= alu_c;
            carry_r <= alu_cout;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_cout  <= 1'b0;
      end else if (done && !port_r) begin
         rsp0_valid <= 1'b1;
         rsp0_data  <= fin_data;
         rsp0_cout  <= alu_cout;
      end else if (rsp0_valid && rsp0_ready) begin
         rsp0_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_cout  <= 1'b0;
      end else if (done && port_r) begin
         rsp1_valid <= 1'b1;
         rsp1_data  <= fin_data;
         rsp1_cout  <= alu_cout;
      end else if (rsp1_valid && rsp1_ready) begin
         rsp1_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU, a per-port result/timing model,
// directed scenarios and a randomized traffic phase.
module tb_alu_arbiter;

   localparam int W = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rq_valid, rq_wide, rq_cin, rs_ready;
   logic [3:0]  rq_op [2];
   logic [31:0] rq_a [2];
   logic [31:0] rq_b [2];
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout;
   logic [31:0] rsp0_data, rsp1_data;
   logic [15:0] alu_a, alu_b, alu_c;
   logic [3:0]  alu_op;
   logic        alu_cin, alu_cout;

   int          vectors = 0;
   int          miscompares = 0;
   int          t = 0;
   int          free_at = 0;
   bit          m_last = 1'b1;
   bit [1:0]    m_have = '0;
   bit [1:0]    m_cout = '0;
   int          m_due [2];
   logic [31:0] m_data [2];
   bit          in_flight = 1'b0;
   int          acc_t = 0;
   logic [3:0]  cur_op;
   bit          cur_wide, cur_cin;
   logic [31:0] cur_a, cur_b;
   bit [1:0]    acc = '0;
   int          grants [$];

   alu_arbiter #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(rq_valid[0]), .req0_ready(req0_ready), .req0_op(rq_op[0]),
      .req0_wide(rq_wide[0]), .req0_cin(rq_cin[0]), .req0_a(rq_a[0]), .req0_b(rq_b[0]),
      .req1_valid(rq_valid[1]), .req1_ready(req1_ready), .req1_op(rq_op[1]),
      .req1_wide(rq_wide[1]), .req1_cin(rq_cin[1]), .req1_a(rq_a[1]), .req1_b(rq_b[1]),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rs_ready[0]), .rsp0_data(rsp0_data), .rsp0_cout(rsp0_cout),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rs_ready[1]), .rsp1_data(rsp1_data), .rsp1_cout(rsp1_cout),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_c(alu_c), .alu_cout(alu_cout)
   );

   initial forever #5 clk = ~clk;

   // Stand-in ALU: result bits [15:0], carry out in bit 16.
   function automatic logic [16:0] aluFn(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
      case (op)
         4'd0:    aluFn = {1'b0, a} + {1'b0, b} + {16'd0, cin};
         4'd1:    aluFn = {1'b0, a} + {1'b0, ~b} + {16'd0, cin};
         4'd2:    aluFn = {1'b0, a & b};
         4'd3:    aluFn = {1'b0, a | b};
         4'd9:    aluFn = {1'b0, a ^ b};
         default: aluFn = {a, cin};
      endcase
   endfunction

   always_comb {alu_cout, alu_c} = aluFn(alu_op, alu_a, alu_b, alu_cin);

   function automatic logic rspValid(input int p);
      return (p == 0) ? rsp0_valid : rsp1_valid;
   endfunction

   function automatic logic [32:0] rspWord(input int p);
      return (p == 0) ? {rsp0_cout, rsp0_data} : {rsp1_cout, rsp1_data};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, t);
      end
   endtask

   task automatic applyStimulus(input int p, input logic [3:0] op, input bit wide, input bit cin,
                                input logic [31:0] a, input logic [31:0] b);
      rq_op[p]    = op;
      rq_wide[p]  = wide;
      rq_cin[p]   = cin;
      rq_a[p]     = a;
      rq_b[p]     = b;
      rq_valid[p] = 1'b1;
   endtask

   task automatic randPayload(input int p, input bit allow_wide);
      rq_op[p]   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rq_wide[p] = allow_wide ? 1'($urandom_range(0, 1)) : 1'b0;
      rq_cin[p]  = 1'($urandom_range(0, 1));
      rq_a[p]    = $urandom;
      rq_b[p]    = $urandom;
      if ($urandom_range(0, 3) == 0) rq_a[p][15:0] = 16'hFFFF;
   endtask

   // One clock: compare DUT against the model, advance the model, step to the next cycle.
   task automatic runCycle();
      bit [1:0]    mv, el, er;
      bit          idle;
      logic [36:0] exp_bus;
      logic [16:0] lo_sum, r;
      logic [32:0] wsum;
      #1;
      idle = !rst && (t >= free_at);
      for (int p = 0; p < 2; p++) begin
         mv[p] = !rst && m_have[p] && (t >= m_due[p]);
         el[p] = rq_valid[p] && !mv[p];
      end
      er[0] = idle && el[0] && (!el[1] || m_last);
      er[1] = idle && el[1] && (!el[0] || !m_last);
      checkOutput("req0_ready", 64'(req0_ready), 64'(er[0]));
      checkOutput("req1_ready", 64'(req1_ready), 64'(er[1]));
      for (int p = 0; p < 2; p++) begin
         checkOutput(p == 0 ? "rsp0_valid" : "rsp1_valid", 64'(rspValid(p)), 64'(mv[p]));
         if (mv[p]) checkOutput(p == 0 ? "rsp0_result" : "rsp1_result",
                                64'(rspWord(p)), 64'({m_cout[p], m_data[p]}));
         if (rst) checkOutput("rst_rsp", 64'(rspWord(p)), 64'(0));
      end
      lo_sum  = {1'b0, cur_a[15:0]} + {1'b0, cur_b[15:0]} + {16'd0, cur_cin};
      exp_bus = '0;
      if (!rst && in_flight && t == acc_t + 1)
         exp_bus = {cur_a[15:0], cur_b[15:0], cur_op, cur_cin};
      else if (!rst && in_flight && cur_wide && t == acc_t + 2)
         exp_bus = {cur_a[31:16], cur_b[31:16], 4'd0, lo_sum[16]};
      checkOutput("alu_bus", 64'({alu_a, alu_b, alu_op, alu_cin}), 64'(exp_bus));
      if (req0_ready && rq_valid[0]) grants.push_back(0);
      if (req1_ready && rq_valid[1]) grants.push_back(1);
      acc = '0;
      if (rst) begin
         m_have    = '0;
         m_last    = 1'b1;
         free_at   = t;
         in_flight = 1'b0;
      end else begin
         for (int p = 0; p < 2; p++)
            if (mv[p] && rs_ready[p]) m_have[p] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (er[p]) begin
               cur_op   = rq_op[p];
               cur_wide = rq_wide[p] && (rq_op[p] == 4'd0);
               cur_cin  = rq_cin[p];
               cur_a    = rq_a[p];
               cur_b    = rq_b[p];
               if (cur_wide) begin
                  wsum = {1'b0, cur_a} + {1'b0, cur_b} + {32'd0, cur_cin};
                  {m_cout[p], m_data[p]} = wsum;
               end else begin
                  r = aluFn(cur_op, cur_a[15:0], cur_b[15:0], cur_cin);
                  m_data[p] = {16'h0, r[15:0]};
                  m_cout[p] = r[16];
               end
               m_have[p] = 1'b1;
               m_due[p]  = t + (cur_wide ? 3 : 2);
               free_at   = m_due[p];
               m_last    = (p == 1);
               acc_t     = t;
               in_flight = 1'b1;
               acc[p]    = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic issue(input int p, input logic [3:0] op, input bit wide, input bit cin,
                        input logic [31:0] a, input logic [31:0] b, output int gt);
      applyStimulus(p, op, wide, cin, a, b);
      gt = -1;
      for (int n = 0; n < 20 && gt < 0; n++) begin
         runCycle();
         if (acc[p]) gt = t - 1;
      end
      rq_valid[p] = 1'b0;
      checkOutput("grant_seen", 64'(gt >= 0), 64'(1));
   endtask

   task automatic checkResponse(input string tag, input int p, input int gt, input int lat,
                                input logic [31:0] data, input bit cout);
      for (int n = 0; n < 10 && !rspValid(p); n++) runCycle();
      checkOutput({tag, "_valid"}, 64'(rspValid(p)), 64'(1));
      checkOutput({tag, "_lat"}, 64'(t - gt), 64'(lat));
      checkOutput({tag, "_data"}, 64'(rspWord(p)), 64'({cout, data}));
   endtask

   task automatic settle();
      rq_valid = '0;
      rs_ready = 2'b11;
      for (int n = 0; n < 6; n++) runCycle();
   endtask

   function automatic int countGrants(input int port);
      int c = 0;
      foreach (grants[i]) if (grants[i] == port) c++;
      return c;
   endfunction

   initial begin
      int gt;
      rst = 1'b1;
      rq_valid = '0; rq_wide = '0; rq_cin = '0; rs_ready = '0;
      for (int p = 0; p < 2; p++) begin
         rq_op[p] = '0; rq_a[p] = '0; rq_b[p] = '0;
      end
      @(posedge clk);
      #1;
      // Requests present during reset must not be accepted.
      applyStimulus(0, 4'd0, 1'b0, 1'b0, 32'h1, 32'h2);
      applyStimulus(1, 4'd0, 1'b0, 1'b0, 32'h3, 32'h4);
      for (int n = 0; n < 3; n++) runCycle();
      rst = 1'b0;
      rq_valid = '0;
      rs_ready = 2'b11;
      runCycle();

      issue(0, 4'd0, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0004, gt);
      checkResponse("narrow_add", 0, gt, 2, 32'h0000_0008, 1'b0);
      runCycle();
      issue(1, 4'd0, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, gt);
      checkResponse("wide_carry", 1, gt, 3, 32'h0001_0000, 1'b0);
      runCycle();
      issue(1, 4'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, gt);
      checkResponse("wide_wrap", 1, gt, 3, 32'h0000_0000, 1'b1);
      runCycle();

      // Round-robin alternation after reset, port 0 first.
      rst = 1'b1;
      runCycle();
      runCycle();
      rst = 1'b0;
      grants.delete();
      randPayload(0, 1'b0);
      randPayload(1, 1'b0);
      rq_valid = 2'b11;
      for (int n = 0; n < 12; n++) begin
         runCycle();
         for (int p = 0; p < 2; p++) if (acc[p]) randPayload(p, 1'b0);
      end
      checkOutput("alt_count", 64'(grants.size() >= 4), 64'(1));
      for (int i = 0; i < 4 && i < grants.size(); i++)
         checkOutput("alt_order", 64'(grants[i]), 64'(i % 2));

      // Port 0 blocked while its response is undrained.
      settle();
      grants.delete();
      rs_ready = 2'b10;
      rq_valid = 2'b11;
      for (int n = 0; n < 20; n++) begin
         runCycle();
         for (int p = 0; p < 2; p++) if (acc[p]) randPayload(p, 1'b0);
      end
      checkOutput("blocked_p0_grants", 64'(countGrants(0)), 64'(1));
      checkOutput("blocked_p1_grants", 64'(countGrants(1) >= 4), 64'(1));
      grants.delete();
      rs_ready = 2'b11;
      for (int n = 0; n < 10; n++) begin
         runCycle();
         for (int p = 0; p < 2; p++) if (acc[p]) randPayload(p, 1'b0);
      end
      checkOutput("drained_p0_regrant", 64'(countGrants(0) >= 1), 64'(1));

      // Wide flag ignored for a non-add opcode.
      settle();
      issue(0, 4'd9, 1'b1, 1'b0, 32'hFFFF_00FF, 32'h0000_FFFF, gt);
      checkResponse("wide_xor", 0, gt, 2, 32'h0000_FF00, 1'b0);
      runCycle();

      // Reset during the high pass discards the operation.
      settle();
      issue(0, 4'd0, 1'b1, 1'b1, 32'h1234_FFFF, 32'h0001_0001, gt);
      runCycle();
      rst = 1'b1;
      rs_ready = 2'b00;
      for (int n = 0; n < 3; n++) runCycle();
      rst = 1'b0;
      runCycle();
      runCycle();
      grants.delete();
      randPayload(0, 1'b0);
      randPayload(1, 1'b0);
      rq_valid = 2'b11;
      runCycle();
      checkOutput("rst_tie_count", 64'(grants.size()), 64'(1));
      if (grants.size() > 0) checkOutput("rst_tie_port", 64'(grants[0]), 64'(0));

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!rq_valid[p] || acc[p]) begin
               rq_valid[p] = ($urandom_range(0, 99) < 60);
               randPayload(p, 1'b1);
            end
         end
         rs_ready[0] = ($urandom_range(0, 99) < 70);
         rs_ready[1] = ($urandom_range(0, 99) < 70);
         runCycle();
      end
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
